// File: rtl/fp_norm_arbiter.sv
// Round-robin arbiter in front of one iterative normalizer: shifts the magnitude left until its MSB is set.
// Define FP_NORM_ARB_B2B_EN to allow a new grant in DONE, so results can be issued back-to-back.
module fp_norm_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int FXP_WIDTH     = 4,
  parameter int EXP_WIDTH     = 5,
  parameter int EXP_OUT_WIDTH = EXP_WIDTH + 1,
  parameter int FP_WIDTH      = FXP_WIDTH + EXP_OUT_WIDTH + 1,
  parameter int TAG_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_sign,
  input  logic [NUM_REQ*FXP_WIDTH-1:0]   req_fxp,
  input  logic [NUM_REQ*EXP_WIDTH-1:0]   req_exp,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [FP_WIDTH-1:0]            out_fp,
  output logic [TAG_WIDTH-1:0]           out_tag,
  output logic                           out_zero
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t                     state, next_state;
  logic                       started_q;
  logic [TAG_WIDTH-1:0]       rr_ptr;
  logic                       sign_q;
  logic [FXP_WIDTH-1:0]       mag_q;
  logic [EXP_OUT_WIDTH-1:0]   exp_q;
  logic [TAG_WIDTH-1:0]       tag_q;
  logic                       zero_q;

  logic                       grant_found;
  logic [TAG_WIDTH-1:0]       grant_idx;
  logic                       lane_sign;
  logic [FXP_WIDTH-1:0]       lane_fxp;
  logic [EXP_WIDTH-1:0]       lane_exp;
  logic                       arb_en;
  logic                       accept;
  logic                       shift;

  function automatic logic [TAG_WIDTH-1:0] wrap_idx(input int v);
    return TAG_WIDTH'(v % NUM_REQ);
  endfunction

  // First valid lane at or after rr_ptr, searching upward with wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[wrap_idx(int'(rr_ptr) + i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(int'(rr_ptr) + i);
      end
    end
  end

  always_comb begin
    lane_sign = 1'b0;
    lane_fxp  = '0;
    lane_exp  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TAG_WIDTH'(i)) begin
        lane_sign = req_sign[i];
        lane_fxp  = req_fxp[i*FXP_WIDTH +: FXP_WIDTH];
        lane_exp  = req_exp[i*EXP_WIDTH +: EXP_WIDTH];
      end
    end
  end

  always_comb begin
    next_state = state;
    arb_en     = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: arb_en = 1'b1;
      NORM: begin
        if (mag_q[FXP_WIDTH-1] || mag_q == '0) next_state = DONE;
        else                                   shift      = 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
`ifdef FP_NORM_ARB_B2B_EN
          arb_en = 1'b1;
`else
          arb_en = 1'b0;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
    // started_q keeps req_ready low until the first edge after reset release.
    accept = arb_en && started_q && grant_found;
    if (accept) next_state = NORM;
  end

  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Datapath registers are reset because out_fp/out_tag/out_zero must read zero out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started_q <= 1'b0;
      rr_ptr    <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      tag_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      started_q <= 1'b1;
      if (accept) begin
        sign_q <= lane_sign;
        mag_q  <= lane_fxp;
        exp_q  <= EXP_OUT_WIDTH'(lane_exp);
        tag_q  <= grant_idx;
        zero_q <= (lane_fxp == '0);
        rr_ptr <= wrap_idx(int'(grant_idx) + 1);
      end else if (shift) begin
        mag_q <= {mag_q[FXP_WIDTH-2:0], 1'b0};
        exp_q <= exp_q - EXP_OUT_WIDTH'(1);
      end
    end
  end

  assign out_valid = (state == DONE);
  assign out_fp    = {sign_q, exp_q, mag_q};
  assign out_tag   = tag_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_fp_norm_arbiter.sv
// Self-checking bench for fp_norm_arbiter: directed cases plus randomized traffic checked every
// cycle against a transaction-level model (leading-zero count, plain arithmetic, countdown).
module tb_fp_norm_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int FXP_WIDTH     = 4;
  localparam int EXP_WIDTH     = 5;
  localparam int EXP_OUT_WIDTH = 6;
  localparam int FP_WIDTH      = 11;
  localparam int TAG_WIDTH     = 2;
`ifdef FP_NORM_ARB_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         resetn;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           req_sign;
  logic [NUM_REQ*FXP_WIDTH-1:0] req_fxp;
  logic [NUM_REQ*EXP_WIDTH-1:0] req_exp;
  logic                         out_valid;
  logic                         out_ready;
  logic [FP_WIDTH-1:0]          out_fp;
  logic [TAG_WIDTH-1:0]         out_tag;
  logic                         out_zero;

  always #5 clk = ~clk;

  fp_norm_arbiter #(
    .NUM_REQ(NUM_REQ), .FXP_WIDTH(FXP_WIDTH), .EXP_WIDTH(EXP_WIDTH),
    .EXP_OUT_WIDTH(EXP_OUT_WIDTH), .FP_WIDTH(FP_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
    .req_fxp(req_fxp), .req_exp(req_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fp(out_fp), .out_tag(out_tag), .out_zero(out_zero)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: one item in flight, m_wait edges until its result is visible.
  bit                  m_started;
  bit                  m_holding;
  int                  m_wait;
  int                  m_rr;
  logic [FP_WIDTH-1:0] m_fp;
  int                  m_tag;
  bit                  m_zero;

  bit collect;
  int tag_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_valid(input int rr, input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic bit arb_allowed();
    return m_started && (!m_holding || (B2B && m_wait == 0 && out_ready));
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    m_holding = 1'b0;
    m_wait    = 0;
    m_rr      = 0;
  endtask

  task automatic compare_outputs();
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    g = arb_allowed() ? first_valid(m_rr, req_valid) : -1;
    exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_holding && m_wait == 0));
    if (m_holding && m_wait == 0) begin
      check("out_fp", 32'(out_fp), 32'(m_fp));
      check("out_tag", 32'(out_tag), 32'(m_tag));
      check("out_zero", 32'(out_zero), 32'(m_zero));
    end
    if (collect && out_valid && out_ready) tag_q.push_back(int'(out_tag));
  endtask

  // Applies what the next rising edge does, using the inputs held across it.
  task automatic model_edge();
    int g, s, f, e, magv, expv;
    g = arb_allowed() ? first_valid(m_rr, req_valid) : -1;
    if (m_holding) begin
      if (m_wait > 0)     m_wait--;
      else if (out_ready) m_holding = 1'b0;
    end
    if (g >= 0) begin
      f = int'(req_fxp[g*FXP_WIDTH +: FXP_WIDTH]);
      e = int'(req_exp[g*EXP_WIDTH +: EXP_WIDTH]);
      s = 0;
      if (f != 0) while (f * (1 << s) < (1 << (FXP_WIDTH - 1))) s++;
      magv = (f * (1 << s)) % (1 << FXP_WIDTH);
      expv = e - s;
      m_fp      = {req_sign[g], EXP_OUT_WIDTH'(expv), FXP_WIDTH'(magv)};
      m_tag     = g;
      m_zero    = (f == 0);
      m_holding = 1'b1;
      m_wait    = s + 1;
      m_rr      = (g + 1) % NUM_REQ;
    end
    m_started = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    compare_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input bit s, input logic [FXP_WIDTH-1:0] f,
                          input logic [EXP_WIDTH-1:0] e);
    req_sign[i] = s;
    req_fxp[i*FXP_WIDTH +: FXP_WIDTH] = f;
    req_exp[i*EXP_WIDTH +: EXP_WIDTH] = e;
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < NUM_REQ; i++)
      set_lane(i, 1'($urandom), FXP_WIDTH'($urandom), EXP_WIDTH'($urandom));
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    randomize_fields();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fp", 32'(out_fp), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    resetn    = 1'b1;
    req_valid = '0;
    #1;
    check("rst_release_req_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic run_one(input string name, input int lane, input bit s,
                         input logic [FXP_WIDTH-1:0] f, input logic [EXP_WIDTH-1:0] e,
                         input logic [FP_WIDTH-1:0] exp_fp, input bit exp_zero, input int exp_lat);
    int lat;
    req_valid = '0;
    req_valid[lane] = 1'b1;
    set_lane(lane, s, f, e);
    out_ready = 1'b1;
    step();
    req_valid = '0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_fp"}, 32'(out_fp), 32'(exp_fp));
    check({name, "_tag"}, 32'(out_tag), 32'(lane));
    check({name, "_zero"}, 32'(out_zero), 32'(exp_zero));
    step();
    check({name, "_single_pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    int n;
    logic [FP_WIDTH-1:0] hold_fp;
    logic [TAG_WIDTH-1:0] hold_tag;

    collect   = 1'b0;
    req_sign  = '0;
    req_fxp   = '0;
    req_exp   = '0;
    do_reset();
    repeat (3) step();

    // Literal expectations from hand calculation.
    run_one("normal", 1, 1'b1, 4'b0010, 5'd10, 11'b1_001000_1000, 1'b0, 3);
    run_one("zero", 2, 1'b0, 4'b0000, 5'd7, 11'b0_000111_0000, 1'b1, 1);
    run_one("underflow", 0, 1'b0, 4'b0001, 5'd1, 11'b0_111110_1000, 1'b0, 4);
    run_one("msb_set", 3, 1'b1, 4'b1010, 5'd0, 11'b1_000000_1010, 1'b0, 1);

    // Round-robin with every lane requesting; fields churn while busy.
    do_reset();
    collect   = 1'b1;
    req_valid = '1;
    n = 0;
    while (tag_q.size() < 6 && n < 300) begin
      step();
      randomize_fields();
      n++;
    end
    collect = 1'b0;
    check("rr_result_count", 32'(tag_q.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < tag_q.size(); k++)
      check($sformatf("rr_tag_%0d", k), 32'(tag_q[k]), 32'(rr_exp[k]));

    // Backpressure while in DONE.
    out_ready = 1'b0;
    req_valid = '1;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("bp_reached_done", 32'(out_valid), 32'd1);
    hold_fp  = out_fp;
    hold_tag = out_tag;
    for (int k = 0; k < 5; k++) begin
      step();
      randomize_fields();
      check("bp_fp_stable", 32'(out_fp), 32'(hold_fp));
      check("bp_tag_stable", 32'(out_tag), 32'(hold_tag));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_released", 32'(out_valid), 32'd0);

    // Reset during NORM of fxp=0001.
    do_reset();
    step();
    req_valid = 4'b0001;
    set_lane(0, 1'b0, 4'b0001, 5'd9);
    step();
    req_valid = '0;
    step();
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_fp", 32'(out_fp), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("midrst_release_ready", 32'(req_ready), 32'd0);
    step();
    check("midrst_first_grant", 32'(req_ready), 32'b0001);

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < NUM_REQ; i++) req_valid[i] = ($urandom_range(0, 9) < 4);
      randomize_fields();
      if ($urandom_range(0, 3) == 0) req_fxp[0 +: FXP_WIDTH] = FXP_WIDTH'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
